srt_div_sched: RTL and testbench

SRT_DIV_SCHED -- requirements
Module: srt_div_sched

---
 rtl/srt_div_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/srt_div_sched.sv | 195 +++++++++++++++++++
 tb/tb_srt_div_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// -----------------------------------------------------------------------------
// srt_div_pkg
// Shared definitions for the divider request scheduler:
//   - state_t     : scheduler FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - W_DEFAULT   : default operand/result width
//   - DZ_Q_FILL   : bit replicated across the quotient on a divide-by-zero
// No ports (package).
// -----------------------------------------------------------------------------
package srt_div_pkg;

    localparam int W_DEFAULT = 64;

    // A divide-by-zero quotient is all ones at whatever width is in use.
    localparam logic DZ_Q_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping modulo NREQ) wins.
// Ports:
//   req       in  NREQ          request vector
//   ptr       in  clog2(NREQ)   highest-priority index this cycle
//   grant     out NREQ          one-hot grant (all zero when no request)
//   grant_idx out clog2(NREQ)   encoded index of the granted requester
//   grant_any out 1             any request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import srt_div_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int IW = $clog2(NREQ);

    function automatic int wrap_idx(input int base, input int offs);
        return (base + offs) % NREQ;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req[wrap_idx(int'(ptr), k)]) begin
                grant_any                       = 1'b1;
                grant[wrap_idx(int'(ptr), k)]   = 1'b1;
                grant_idx                       = IW'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/srt_div_sched.sv
// -----------------------------------------------------------------------------
// srt_div_sched
// Shares one external multi-cycle divider among NREQ requesters. A request is
// granted round-robin in IDLE, launched with a one-cycle DIV_START, the result
// is captured on DIV_DONE and presented until RSP_READY.
//
// Optional feature macro: SRT_DIV_ZERO_BYPASS_EN
//   When defined, a granted request with a zero divisor never reaches the
//   divider; it responds directly with quotient all-ones, remainder equal to
//   the dividend and RSP_DZ=1. Otherwise RSP_DZ is tied to 0.
//
// Ports:
//   CLK        in  1            clock, rising edge
//   RST_N      in  1            asynchronous active-low reset
//   REQ_VALID  in  NREQ         per-requester request valid
//   REQ_READY  out NREQ         per-requester accept (one-hot, IDLE only)
//   REQ_DVD    in  NREQ*W       packed dividends, requester i at [i*W +: W]
//   REQ_DSR    in  NREQ*W       packed divisors, same packing
//   RSP_VALID  out 1            response valid
//   RSP_READY  in  1            response accept
//   RSP_ID     out clog2(NREQ)  owning requester
//   RSP_Q      out W            quotient
//   RSP_R      out W            remainder
//   RSP_DZ     out 1            divide-by-zero flag
//   DIV_START  out 1            one-cycle launch pulse to the divider
//   DIV_DVD    out W            dividend to the divider
//   DIV_DSR    out W            divisor to the divider
//   DIV_DONE   in  1            divider completion pulse
//   DIV_Q      in  W            divider quotient
//   DIV_R      in  W            divider remainder
// -----------------------------------------------------------------------------
module srt_div_sched
    import srt_div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         REQ_VALID,
    output logic [NREQ-1:0]         REQ_READY,
    input  logic [NREQ*W-1:0]       REQ_DVD,
    input  logic [NREQ*W-1:0]       REQ_DSR,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [$clog2(NREQ)-1:0] RSP_ID,
    output logic [W-1:0]            RSP_Q,
    output logic [W-1:0]            RSP_R,
    output logic                    RSP_DZ,
    output logic                    DIV_START,
    output logic [W-1:0]            DIV_DVD,
    output logic [W-1:0]            DIV_DSR,
    input  logic                    DIV_DONE,
    input  logic [W-1:0]            DIV_Q,
    input  logic [W-1:0]            DIV_R
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic            accept;
    logic            zero_bypass;

    logic [W-1:0]    sel_dvd;
    logic [W-1:0]    sel_dsr;

    logic [W-1:0]    dvd_q;
    logic [W-1:0]    dsr_q;
    logic [IW-1:0]   id_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_dvd = REQ_DVD[int'(grant_idx)*W +: W];
    assign sel_dsr = REQ_DSR[int'(grant_idx)*W +: W];
    assign accept  = (state == IDLE) && grant_any;

`ifdef SRT_DIV_ZERO_BYPASS_EN
    assign zero_bypass = (sel_dsr == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        REQ_READY = '0;
        DIV_START = 1'b0;
        RSP_VALID = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = grant;
                if (grant_any) begin
                    state_nxt = zero_bypass ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                DIV_START = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (DIV_DONE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Operands are captured at accept and stay put through ISSUE and WAIT;
    // results are captured from the divider only while waiting for it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dvd_q <= '0;
            dsr_q <= '0;
            id_q  <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            if (accept) begin
                dvd_q <= sel_dvd;
                dsr_q <= sel_dsr;
                id_q  <= grant_idx;
                if (zero_bypass) begin
                    quo_q <= {W{DZ_Q_FILL}};
                    rem_q <= sel_dvd;
                end
            end
            if ((state == WAIT) && DIV_DONE) begin
                quo_q <= DIV_Q;
                rem_q <= DIV_R;
            end
        end
    end

`ifdef SRT_DIV_ZERO_BYPASS_EN
    logic dz_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dz_q <= 1'b0;
        end else begin
            if (accept) begin
                dz_q <= zero_bypass;
            end else if ((state == WAIT) && DIV_DONE) begin
                dz_q <= 1'b0;
            end
        end
    end

    assign RSP_DZ = dz_q;
`else
    assign RSP_DZ = 1'b0;
`endif

    assign DIV_DVD = dvd_q;
    assign DIV_DSR = dsr_q;
    assign RSP_ID  = id_q;
    assign RSP_Q   = quo_q;
    assign RSP_R   = rem_q;

endmodule

// File: tb/tb_srt_div_sched.sv
// -----------------------------------------------------------------------------
// tb_srt_div_sched
// Directed bench for srt_div_sched with a transaction-level reference model
// and a behavioural divider responder. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_srt_div_sched;
    import srt_div_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int IW   = 2;

`ifdef SRT_DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_dvd = '0;
    logic [NREQ*W-1:0]   req_dsr = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IW-1:0]       rsp_id;
    logic [W-1:0]        rsp_q;
    logic [W-1:0]        rsp_r;
    logic                rsp_dz;
    logic                div_start;
    logic [W-1:0]        div_dvd;
    logic [W-1:0]        div_dsr;
    logic                div_done = 1'b0;
    logic [W-1:0]        div_q = '0;
    logic [W-1:0]        div_r = '0;

    srt_div_sched #(.NREQ(NREQ), .W(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_DVD   (req_dvd),
        .REQ_DSR   (req_dsr),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_ID    (rsp_id),
        .RSP_Q     (rsp_q),
        .RSP_R     (rsp_r),
        .RSP_DZ    (rsp_dz),
        .DIV_START (div_start),
        .DIV_DVD   (div_dvd),
        .DIV_DSR   (div_dsr),
        .DIV_DONE  (div_done),
        .DIV_Q     (div_q),
        .DIV_R     (div_r)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endfunction

    // ---------------- behavioural divider ----------------
    int          lat = 1;
    int          spur_at = -1;
    logic        d_pend = 1'b0;
    int          d_cnt = 0;
    logic [W-1:0] d_q = '0;
    logic [W-1:0] d_r = '0;

    initial begin
        forever begin
            @(negedge CLK);
            if (div_start === 1'b1) begin
                d_pend = 1'b1;
                d_cnt  = lat;
                if (div_dsr != 0) begin
                    d_q = div_dvd / div_dsr;
                    d_r = div_dvd % div_dsr;
                end else begin
                    d_q = '1;
                    d_r = div_dvd;
                end
            end
            @(posedge CLK);
            #1;
            div_done = 1'b0;
            if (d_pend) begin
                d_cnt--;
                if (d_cnt == 0) begin
                    div_done = 1'b1;
                    div_q    = d_q;
                    div_r    = d_r;
                    d_pend   = 1'b0;
                end
            end
            if (!div_done && cyc == spur_at) begin
                div_done = 1'b1;
                div_q    = 64'hDEAD;
                div_r    = 64'hBEEF;
            end
        end
    end

    // ---------------- transaction-level reference model + compare ----------------
    logic         m_busy = 1'b0;
    logic         m_started = 1'b0;
    logic         m_resp = 1'b0;
    logic         m_byp = 1'b0;
    int           m_ptr = 0;
    int           m_acc = 0;
    int           m_id = 0;
    logic [W-1:0] m_dvd = '0;
    logic [W-1:0] m_dsr = '0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    int           grant_log[$];
    int           n_start = 0;
    int           n_resp = 0;
    logic [W-1:0] last_id = '0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic [W-1:0] last_dz = '0;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_q", rsp_q, 0);
                chk("rst_rsp_r", rsp_r, 0);
                chk("rst_rsp_dz", rsp_dz, 0);
                chk("rst_div_start", div_start, 0);
                chk("rst_div_dvd", div_dvd, 0);
                chk("rst_div_dsr", div_dsr, 0);
                m_busy = 1'b0; m_started = 1'b0; m_resp = 1'b0; m_ptr = 0;
            end else begin
                int g;
                logic [NREQ-1:0] exp_rdy;
                logic waiting;
                logic exp_start;
                g = -1;
                exp_rdy = '0;
                if (!m_busy) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                    end
                    if (g >= 0) exp_rdy[g] = 1'b1;
                end
                chk("req_ready", req_ready, exp_rdy);

                waiting   = m_busy && m_started && !m_resp;
                exp_start = m_busy && !m_byp && (cyc == m_acc + 1);
                chk("div_start", div_start, exp_start);
                if (exp_start || waiting) begin
                    chk("div_dvd", div_dvd, m_dvd);
                    chk("div_dsr", div_dsr, m_dsr);
                end

                chk("rsp_valid", rsp_valid, m_resp);
                if (m_resp) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_q", rsp_q, m_q);
                    chk("rsp_r", rsp_r, m_r);
                    chk("rsp_dz", rsp_dz, m_byp);
                end

                if (div_start) begin
                    n_start++;
                    m_started = 1'b1;
                end
                if (m_resp && rsp_ready) begin
                    n_resp++;
                    last_id = rsp_id; last_q = rsp_q; last_r = rsp_r; last_dz = rsp_dz;
                    m_busy = 1'b0;
                    m_resp = 1'b0;
                end else if (waiting && div_done) begin
                    m_resp = 1'b1;
                end
                if (g >= 0) begin
                    m_busy    = 1'b1;
                    m_started = 1'b0;
                    m_id      = g;
                    m_acc     = cyc;
                    m_dvd     = req_dvd[g*W +: W];
                    m_dsr     = req_dsr[g*W +: W];
                    m_byp     = BYP && (m_dsr == 0);
                    m_resp    = m_byp;
                    m_q       = (m_dsr != 0) ? m_dvd / m_dsr : '1;
                    m_r       = (m_dsr != 0) ? m_dvd % m_dsr : m_dvd;
                    m_ptr     = (g + 1) % NREQ;
                    grant_log.push_back(g);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int id, input logic [W-1:0] dvd, input logic [W-1:0] dsr);
        bit ok;
        ok = 1'b0;
        req_dvd[id*W +: W] = dvd;
        req_dsr[id*W +: W] = dsr;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("send_accept");
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (rsp_valid && rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("rsp_handshake");
        tick();
    endtask

    initial begin
        int n0;
        int r0;
        int base;
        bit ok;

        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        // all four requesters at once, pointer fresh from reset
        lat = 2;
        base = grant_log.size();
        for (int i = 0; i < NREQ; i++) begin
            req_dvd[i*W +: W] = 64'(100 + 10 * i);
            req_dsr[i*W +: W] = 64'(i + 3);
        end
        req_valid = '1;
        for (int n = 0; n < 400 && req_valid != 0; n++) begin
            logic [NREQ-1:0] taken;
            @(negedge CLK);
            taken = req_ready;
            tick();
            req_valid = req_valid & ~taken;
        end
        if (req_valid != 0) timeout_fail("rr_all_accept");
        req_valid = '0;
        wait_rsp();
        chk("rr_count", 64'(grant_log.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < grant_log.size()) chk("rr_order", 64'(grant_log[base + i]), 64'(i));
        end
        chk("rr_last_q", last_q, 64'd21);
        chk("rr_last_r", last_r, 64'd4);

        // single request, slow divider
        lat = 10;
        n0 = n_start;
        send(2, 64'd74, 64'd21);
        wait_rsp();
        chk("single_id", last_id, 64'd2);
        chk("single_q", last_q, 64'd3);
        chk("single_r", last_r, 64'd11);
        chk("single_dz", last_dz, 64'd0);
        chk("single_starts", 64'(n_start - n0), 64'd1);

        // response backpressure with a competing request pending
        lat = 3;
        rsp_ready = 1'b0;
        send(1, 64'd100, 64'd7);
        req_dvd[3*W +: W] = 64'd45;
        req_dsr[3*W +: W] = 64'd6;
        req_valid[3] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("bp_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge CLK);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_q", rsp_q, 64'd14);
            chk("bp_r", rsp_r, 64'd2);
            chk("bp_no_grant", req_ready, 0);
        end
        tick();
        rsp_ready = 1'b1;
        wait_rsp();
        chk("bp_q_final", last_q, 64'd14);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (req_ready[3]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("bp_next_accept");
        tick();
        req_valid[3] = 1'b0;
        wait_rsp();
        chk("bp_next_q", last_q, 64'd7);
        chk("bp_next_r", last_r, 64'd3);

        // spurious completion while idle
        r0 = n_resp;
        spur_at = cyc + 1;
        repeat (4) tick();
        chk("spur_idle_resp", 64'(n_resp - r0), 0);
        chk("spur_idle_valid", rsp_valid, 0);

        // spurious completion during the launch cycle
        lat = 3;
        req_dvd[0 +: W] = 64'd9;
        req_dsr[0 +: W] = 64'd4;
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (req_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("spur_issue_accept");
        spur_at = cyc + 1;
        tick();
        req_valid[0] = 1'b0;
        wait_rsp();
        chk("spur_issue_q", last_q, 64'd2);
        chk("spur_issue_r", last_r, 64'd1);

        // reset while waiting on the divider; its late completion is dropped
        lat = 20;
        r0 = n_resp;
        send(3, 64'd500, 64'd9);
        repeat (4) tick();
        RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (25) tick();
        chk("rst_mid_resp", 64'(n_resp - r0), 0);
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_q", rsp_q, 0);
        chk("rst_mid_dvd", div_dvd, 0);

        // zero divisor
        lat = 2;
        n0 = n_start;
        send(1, 64'd55, 64'd0);
        wait_rsp();
        chk("dz_q", last_q, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_r", last_r, 64'd55);
        chk("dz_id", last_id, 64'd1);
`ifdef SRT_DIV_ZERO_BYPASS_EN
        chk("dz_flag", last_dz, 64'd1);
        chk("dz_starts", 64'(n_start - n0), 64'd0);
`else
        chk("dz_flag", last_dz, 64'd0);
        chk("dz_starts", 64'(n_start - n0), 64'd1);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
